rf_pulse_sequencer: RTL
=======================

Name: rf_pulse_sequencer

Overview:
Parametrised RF pulse-sequence generator for the atom-interferometry FPGA. It replaces the fixed Mach-Zehnder / Rabi controller with one engine that supports three modes: Mach-Zehnder (pi/2–pi–pi/2), Ramsey (pi/2–pi/2) and Rabi (single pulse whose length steps each shot). All phase lengths are parameters. Each shot is launched by an edge from the Arduino trigger pin, and the block drives the RF-switch control pin.

Parameters:
CNT_W, 32, width of phase counter and Rabi length register (must hold WAIT_CYCLES)
START_CYCLES, 400, lead-in delay before first pulse
PI_2_CYCLES, 333, pi/2 pulse length; pi pulse = 2*PI_2_CYCLES
WAIT_CYCLES, 66600, free-evolution gap between pulses
END_CYCLES, 33300, tail hold-off after last pulse, before re-arm
RABI_INIT, 66, first Rabi pulse length (>=1)
RABI_STEP, 66, Rabi length increment per completed shot
RABI_MAX, 6600, largest Rabi length; exceeding it wraps to RABI_INIT
SHOT_W, 16, width of shot counter

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
trig  in  1  asynchronous shot trigger from Arduino; rising edge starts a shot
mode  in  2  0=MZ, 1=Ramsey, 2=Rabi, 3=reserved; sampled on accepted edge
rabi_clear  in  1  level; returns Rabi length to RABI_INIT
rf  out  1  RF switch control, registered
busy  out  1  high from shot acceptance until end of TAIL
done  out  1  one-cycle pulse on last TAIL cycle
trig_miss  out  1  one-cycle pulse when an edge arrives while busy
mode_err  out  1  one-cycle pulse when an edge arrives with mode=3
rabi_len  out  CNT_W  current Rabi pulse length
shot_count  out  SHOT_W  completed shots, wraps modulo 2^SHOT_W

Behaviour:
- Reset (async, rst_n=0): state IDLE, counter 0, rf=0, busy=0, done=0, trig_miss=0, mode_err=0, rabi_len=RABI_INIT, shot_count=0. Asserting reset mid-shot forces rf low immediately, with no completion pulse.
- trig passes through a 2-flop synchroniser, then registered rising-edge detect (trig_sync); edge latency 3 clk.
- Edge in IDLE with mode 0..2: latch mode, enter LEAD next cycle, busy=1. Edge with mode=3: stay IDLE, mode_err=1 for one cycle. Edge while busy: ignored, trig_miss=1 for one cycle.
- States: IDLE, LEAD, P1, GAP1, P2, GAP2, P3, TAIL. Each phase lasts exactly its length in cycles; counter loads 0 on entry and the phase exits when counter==len-1.
- MZ: LEAD(START) P1(PI_2) GAP1(WAIT) P2(2*PI_2) GAP2(WAIT) P3(PI_2) TAIL(END).
- Ramsey: LEAD P1(PI_2) GAP1(WAIT) P3(PI_2) TAIL; P2 and GAP2 are skipped.
- Rabi: LEAD P1(rabi_len sampled at LEAD entry) TAIL.
- rf is registered from the next-state decode. rf=1 exactly during cycles spent in P1/P2/P3 and 0 elsewhere, with no glitch between phases.
- Last TAIL cycle: done=1, shot_count+1, return to IDLE. A new edge is accepted the following cycle.
- Rabi update at shot end, Rabi mode only: rabi_len+RABI_STEP, or RABI_INIT if the sum exceeds RABI_MAX. Sum computed at CNT_W+1 bits, no overflow. rabi_clear in IDLE applies next cycle. If rabi_clear is high at a Rabi shot end, it overrides the increment. rabi_clear during busy has no effect on the running pulse.
- Parameters with value 0 are illegal; a synthesis-time check flags them.

Decomposition:
- Package rf_seq_pkg: state enum (8 states, 3 bits), mode encodings MODE_MZ/MODE_RAMSEY/MODE_RABI/MODE_RSVD.
- Sub-module trig_sync: 2-flop synchroniser plus rising-edge pulse; shared with the future photodiode-trigger input.

Test Plan:
(sim params START=4, PI_2=3, WAIT=10, END=5, RABI_INIT=2, STEP=2, MAX=6)
- MZ shot: one trig edge, mode=0 -> rf high runs of 3, 6, 3 cycles separated by 10 low cycles; first rf high 4 cycles after LEAD entry; busy high for 41 cycles; one done; shot_count=1.
- Ramsey: mode=1 -> rf runs 3 and 3 separated by 10 low cycles; busy 25 cycles.
- Rabi stepping: four shots, mode=2 -> rf widths 2, 4, 6, 2 (wrap); rabi_len after each shot 4, 6, 2, 4.
- Edge during GAP1 -> trig_miss one cycle, waveform unchanged. Edge with mode=3 in IDLE -> mode_err one cycle, rf stays 0, busy stays 0.
- rst_n low mid-P2 -> rf=0 in the same cycle (async); after release, IDLE, shot_count=0, rabi_len=2, next edge gives a clean full MZ sequence.
- rabi_clear held high at the end of a Rabi shot with rabi_len=4 -> rabi_len=2, not 6.

Source files
------------

// File: rtl/rf_pulse_sequencer_pkg.sv
// rf_seq_pkg: shared state and mode encodings for the RF pulse sequencer
package rf_seq_pkg;
    typedef enum logic [2:0] {S_IDLE, S_LEAD, S_P1, S_GAP1, S_P2, S_GAP2, S_P3, S_TAIL} state_t;
    localparam logic [1:0] MODE_MZ     = 2'd0;
    localparam logic [1:0] MODE_RAMSEY = 2'd1;
    localparam logic [1:0] MODE_RABI   = 2'd2;
    localparam logic [1:0] MODE_RSVD   = 2'd3;
endpackage

// File: rtl/rf_pulse_sequencer_trig_sync.sv
// trig_sync: 2-flop synchroniser with registered rising-edge pulse
module trig_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic trig,
    output logic rise
);
    logic s1, s2, s3;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
            rise <= 1'b0;
        end else begin
            s1 <= trig;
            s2 <= s1;
            s3 <= s2;
            rise <= s2 & ~s3;
        end
    end
endmodule

// File: rtl/rf_pulse_sequencer.sv
// rf_pulse_sequencer: triggered MZ / Ramsey / Rabi RF pulse-sequence generator
module rf_pulse_sequencer
    import rf_seq_pkg::*;
#(
    parameter int CNT_W        = 32,
    parameter int START_CYCLES = 400,
    parameter int PI_2_CYCLES  = 333,
    parameter int WAIT_CYCLES  = 66600,
    parameter int END_CYCLES   = 33300,
    parameter int RABI_INIT    = 66,
    parameter int RABI_STEP    = 66,
    parameter int RABI_MAX     = 6600,
    parameter int SHOT_W       = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              trig,
    input  logic [1:0]        mode,
    input  logic              rabi_clear,
    output logic              rf,
    output logic              busy,
    output logic              done,
    output logic              trig_miss,
    output logic              mode_err,
    output logic [CNT_W-1:0]  rabi_len,
    output logic [SHOT_W-1:0] shot_count
);
    if (CNT_W == 0 || START_CYCLES == 0 || PI_2_CYCLES == 0 || WAIT_CYCLES == 0 || END_CYCLES == 0 ||
        RABI_INIT == 0 || RABI_STEP == 0 || RABI_MAX == 0 || SHOT_W == 0) begin : g_bad_param
        $error("rf_pulse_sequencer: zero-valued parameter");
    end

    logic             rise, last;
    state_t           state, nxt;
    logic [CNT_W-1:0] cnt, len, plen;
    logic [CNT_W:0]   sum;
    logic [1:0]       cur_mode;

    trig_sync u_sync (.clk(clk), .rst_n(rst_n), .trig(trig), .rise(rise));

    assign sum  = {1'b0, rabi_len} + (CNT_W+1)'(RABI_STEP);
    assign done = state == S_TAIL && last;

    always_comb begin
        len = state == S_LEAD ? CNT_W'(START_CYCLES) :
              state == S_P1 ? (cur_mode == MODE_RABI ? plen : CNT_W'(PI_2_CYCLES)) :
              (state == S_GAP1 || state == S_GAP2) ? CNT_W'(WAIT_CYCLES) :
              state == S_P2 ? CNT_W'(2 * PI_2_CYCLES) :
              state == S_P3 ? CNT_W'(PI_2_CYCLES) : CNT_W'(END_CYCLES);
        last = cnt == len - CNT_W'(1);
        nxt = state;
        if (state == S_IDLE)
            nxt = (rise && mode != MODE_RSVD) ? S_LEAD : S_IDLE;
        else if (last)
            nxt = state == S_LEAD ? S_P1 :
                  state == S_P1 ? (cur_mode == MODE_RABI ? S_TAIL : S_GAP1) :
                  state == S_GAP1 ? (cur_mode == MODE_MZ ? S_P2 : S_P3) :
                  state == S_P2 ? S_GAP2 :
                  state == S_GAP2 ? S_P3 :
                  state == S_P3 ? S_TAIL : S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            rf         <= 1'b0;
            busy       <= 1'b0;
            trig_miss  <= 1'b0;
            mode_err   <= 1'b0;
            cur_mode   <= MODE_MZ;
            plen       <= '0;
            rabi_len   <= CNT_W'(RABI_INIT);
            shot_count <= '0;
        end else begin
            state     <= nxt;
            cnt       <= (nxt != state || state == S_IDLE) ? '0 : cnt + CNT_W'(1);
            rf        <= nxt == S_P1 || nxt == S_P2 || nxt == S_P3;
            busy      <= nxt != S_IDLE;
            trig_miss <= rise && state != S_IDLE;
            mode_err  <= rise && state == S_IDLE && mode == MODE_RSVD;
            if (state == S_IDLE && nxt == S_LEAD) begin
                cur_mode <= mode;
                plen     <= rabi_len;
            end
            // clear wins over the step at a Rabi shot end; otherwise it only acts while idle
            if (done) begin
                shot_count <= shot_count + SHOT_W'(1);
                if (cur_mode == MODE_RABI)
                    rabi_len <= (rabi_clear || sum > (CNT_W+1)'(RABI_MAX)) ? CNT_W'(RABI_INIT) : sum[CNT_W-1:0];
            end else if (state == S_IDLE && rabi_clear)
                rabi_len <= CNT_W'(RABI_INIT);
        end
    end
endmodule
